// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IMEM, and hands
// {instr, pc, valid} to decode with stall hold, redirect squash and a fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_dout,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic [31:0] fetch_count
);

    logic [31:0] r_pc_f;
    logic        r_started;
    logic [31:0] r_hold_instr;
    logic        r_held;
    logic [31:0] r_cnt;

    logic [31:0] w_next_pc;
    logic        w_valid;
    logic        w_accept;

    always_comb begin
        w_next_pc = r_pc_f + 32'd4;
        if (redirect_valid) begin
            w_next_pc = {redirect_pc[31:2], 2'b00};
        end else if (!r_started || stall) begin
            w_next_pc = r_pc_f;
        end
    end

    // The wrong-path word sitting on the outputs in a redirect cycle is killed here.
    assign w_valid  = rst_n & r_started & ~redirect_valid;
    assign w_accept = w_valid & ~stall;

    assign imem_addr   = rst_n ? w_next_pc : RESET_PC;
    assign imem_en     = rst_n;
    assign if_pc       = rst_n ? r_pc_f : RESET_PC;
    assign if_valid    = w_valid;
    assign if_instr    = !w_valid ? NOP_INSTR : (r_held ? r_hold_instr : imem_dout);
    assign fetch_count = rst_n ? r_cnt : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_f    <= RESET_PC;
            r_started <= 1'b0;
            r_held    <= 1'b0;
            r_cnt     <= 32'd0;
        end else begin
            r_pc_f    <= w_next_pc;
            r_started <= 1'b1;
            if (w_accept) begin
                r_cnt <= r_cnt + 32'd1;
            end
            // Capture only a real instruction so the IMEM word may change under a stall.
            if (redirect_valid) begin
                r_held <= 1'b0;
            end else if (stall && !r_held && r_started) begin
                r_hold_instr <= imem_dout;
                r_held       <= 1'b1;
            end else if (!stall) begin
                r_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural synchronous IMEM, scoreboard of expected
// {pc, instr} pairs popped whenever decode accepts, plus directed cycle checks.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_dout;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [31:0] fetch_count;

    logic [31:0] mem [logic [31:0]];
    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_dout(imem_dout),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_dout <= word(imem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{pc: a, instr: word(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every instruction decode accepts must be the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (if_valid && !stall) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("sb_pc", if_pc, e.pc);
                check_eq("sb_instr", if_instr, e.instr);
                $display("accept pc=%08h instr=%08h count=%0d", if_pc, if_instr, fetch_count);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old_w;
        logic [31:0] tgt;
        logic [31:0] tgt2;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        mem[RST_PC] = 32'h0050_0093;
        old_w = word(RST_PC + 32'h20);
        tgt   = 32'h1000_0020;
        tgt2  = 32'h2000_0100;

        next_cycle(); next_cycle();
        @(negedge clk);
        check_eq("rst_valid", 32'(if_valid), 32'd0);
        check_eq("rst_en", 32'(imem_en), 32'd0);
        check_eq("rst_addr", imem_addr, RST_PC);
        check_eq("rst_instr", if_instr, NOP);
        check_eq("rst_pc", if_pc, RST_PC);
        check_eq("rst_count", fetch_count, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        expect_seq(RST_PC, 10);

        @(negedge clk);                                  // cycle 1
        check_eq("c1_valid", 32'(if_valid), 32'd0);
        check_eq("c1_addr", imem_addr, RST_PC);
        check_eq("c1_en", 32'(imem_en), 32'd1);
        next_cycle(); @(negedge clk);                    // cycle 2
        check_eq("c2_valid", 32'(if_valid), 32'd1);
        check_eq("c2_pc", if_pc, RST_PC);
        check_eq("c2_instr", if_instr, 32'h0050_0093);
        check_eq("c2_addr", imem_addr, RST_PC + 32'd4);
        check_eq("c2_count", fetch_count, 32'd0);
        for (int c = 3; c <= 9; c++) begin
            next_cycle(); @(negedge clk);
            check_eq("seq_pc", if_pc, RST_PC + 32'(4 * (c - 2)));
        end

        next_cycle(); stall = 1'b1; @(negedge clk);     // cycle 10, stall 1
        check_eq("seq_count8", fetch_count, 32'd8);
        for (int s = 0; s < 3; s++) begin
            if (s != 0) begin
                next_cycle();
                if (s == 1) mem[RST_PC + 32'h20] = 32'hDEAD_BEEF;
                @(negedge clk);
            end
            check_eq("stall_pc", if_pc, RST_PC + 32'h20);
            check_eq("stall_instr", if_instr, old_w);
            check_eq("stall_valid", 32'(if_valid), 32'd1);
            check_eq("stall_count", fetch_count, 32'd8);
            check_eq("stall_addr", imem_addr, RST_PC + 32'h20);
        end
        next_cycle(); stall = 1'b0; @(negedge clk);     // cycle 13
        check_eq("unstall_instr", if_instr, old_w);
        check_eq("unstall_addr", imem_addr, RST_PC + 32'h24);
        next_cycle(); @(negedge clk);                    // cycle 14
        check_eq("post_stall_pc", if_pc, RST_PC + 32'h24);
        check_eq("post_stall_count", fetch_count, 32'd9);

        next_cycle();                                    // cycle 15: redirect
        redirect_valid = 1'b1; redirect_pc = 32'h1000_0023;
        expect_seq(tgt, 2);
        @(negedge clk);
        check_eq("redir_valid", 32'(if_valid), 32'd0);
        check_eq("redir_instr", if_instr, NOP);
        check_eq("redir_addr", imem_addr, tgt);
        next_cycle(); redirect_valid = 1'b0; @(negedge clk);
        check_eq("redir_tgt_pc", if_pc, tgt);
        check_eq("redir_tgt_valid", 32'(if_valid), 32'd1);
        next_cycle();                                    // cycle 17
        next_cycle(); stall = 1'b1; @(negedge clk);     // cycle 18
        check_eq("stall2_pc", if_pc, tgt + 32'd8);
        next_cycle();                                    // cycle 19: redirect in stall
        redirect_valid = 1'b1; redirect_pc = 32'h2000_0101;
        expect_seq(tgt2, 1);
        @(negedge clk);
        check_eq("sredir_valid", 32'(if_valid), 32'd0);
        check_eq("sredir_addr", imem_addr, tgt2);
        next_cycle(); stall = 1'b0; redirect_valid = 1'b0; @(negedge clk);
        check_eq("sredir_pc", if_pc, tgt2);
        check_eq("sredir_instr", if_instr, word(tgt2));
        check_eq("sredir_count", fetch_count, 32'd12);

        next_cycle();                                    // cycle 21: jump to top of memory
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        expect_seq(32'hFFFF_FFFC, 2);
        next_cycle(); redirect_valid = 1'b0; @(negedge clk);
        check_eq("wrap_top_pc", if_pc, 32'hFFFF_FFFC);
        next_cycle(); @(negedge clk);
        check_eq("wrap_zero_pc", if_pc, 32'h0000_0000);
        check_eq("wrap_addr", imem_addr, 32'h0000_0004);
        next_cycle(); stall = 1'b1;                      // cycle 24
        next_cycle(); rst_n = 1'b0; @(negedge clk);     // cycle 25: reset mid-stall
        check_eq("mrst_valid", 32'(if_valid), 32'd0);
        check_eq("mrst_count", fetch_count, 32'd0);
        check_eq("mrst_addr", imem_addr, RST_PC);
        check_eq("mrst_instr", if_instr, NOP);
        next_cycle(); rst_n = 1'b1; stall = 1'b0;
        check_eq("mrst_sb_drained", 32'(sb_q.size()), 32'd0);
        expect_seq(RST_PC, 3);
        @(negedge clk);
        check_eq("rs1_valid", 32'(if_valid), 32'd0);
        check_eq("rs1_addr", imem_addr, RST_PC);
        check_eq("rs1_count", fetch_count, 32'd0);
        next_cycle(); @(negedge clk);
        check_eq("rs2_pc", if_pc, RST_PC);
        check_eq("rs2_valid", 32'(if_valid), 32'd1);
        next_cycle(); next_cycle(); @(negedge clk);
        check_eq("rs4_count", fetch_count, 32'd2);
        next_cycle(); stall = 1'b1; @(negedge clk);
        check_eq("final_count", fetch_count, 32'd3);
        check_eq("final_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
